uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the board's uart transmitter. Samples a serial rx pin with a fixed clock divider and mid-bit sampling. Queues received bytes in a small FIFO that the CPU pops through a memory-mapped read strobe. Reports framing and overrun errors as sticky flags. Sits beside uart0 on the 0xE000xxxx chip select.

Parameters:
CLKDIV, 434, clk cycles per bit (50 MHz / 115200); legal range 4..65535.
DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial input; idle high.
re  in  1  pop strobe; 1-cycle pulse removes the head byte.
clr_err  in  1  clears frame_err and overrun.
rdata  out  8  head byte of the FIFO; 0x00 when empty.
rx_valid  out  1  FIFO not empty.
frame_err  out  1  sticky; a stop bit was sampled low.
overrun  out  1  sticky; a byte was dropped because the FIFO was full.
busy  out  1  receiver is not in IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Reset:
  - state IDLE, FIFO empty, rdata=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - synchronizer flops preset to 1.
  - reset mid-frame abandons the partial byte.
- Sync: rx passes through a 2-flop synchronizer; all decisions use the synced value (rxs).
- Bit timer: down-counter of width clog2(CLKDIV). "tick" is the cycle the counter equals 0.
- FSM:
  - IDLE: busy=0. When rxs==0, load counter with CLKDIV/2-1 and go to START.
  - START: on tick, if rxs==1 it was a glitch, so return to IDLE with nothing recorded. Otherwise load counter CLKDIV-1, set bitcnt=0, go to DATA.
  - DATA: on tick, shift rxs into the MSB of shift reg (bytes arrive LSB first) and reload CLKDIV-1. After the bit with bitcnt==7, go to STOP; otherwise increment bitcnt.
  - STOP: on tick, if rxs==1, push the shift reg to the FIFO. If rxs==0, set frame_err and discard the byte. Either way go to IDLE in the same tick, so a start bit immediately following mid-stop is caught.
- Latency: rx_valid and rdata update the cycle after the STOP tick.
- FIFO:
  - 2^DEPTH_LOG2 entries; read/write pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - full when pointer MSBs differ and the low bits are equal.
  - rdata is the combinational read of the head entry, forced to 0x00 when empty.
- Pop: re while empty is ignored. re while non-empty advances the read pointer.
- Push while full:
  - with re in the same cycle, the pop is applied first and the push succeeds.
  - without re, the byte is dropped and overrun is set.
- Flags: clr_err clears both flags. If a set event and clr_err occur in the same cycle, the set wins.
- No parity, single stop bit, no break detection.

Test Plan:
(all with CLKDIV=16, DEPTH_LOG2=2)
1. Drive 0x55 as 8N1, 16 clk/bit -> rx_valid=1 within 160 cycles of the start edge, rdata=0x55, frame_err=0. One-cycle re -> rx_valid=0 and rdata=0x00 next cycle.
2. rx low for 4 cycles, then high -> no push, busy returns to 0 within 12 cycles, rx_valid stays 0.
3. Send 0xA3 with the stop bit held low -> rx_valid stays 0, frame_err=1. Pulse clr_err -> frame_err=0. Next clean byte 0x3C is received correctly.
4. Send 0x01..0x05 with no reads -> overrun=1 after the 5th stop. Four pops return 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
5. Send 0x00 then 0xFF back-to-back, with the second start bit immediately after the first stop bit -> both bytes received in order, frame_err=0.
6. Assert reset during bit 4 of 0x96 -> all outputs return to reset values. Then send 0x5A -> rdata=0x5A, flags 0. Also assert re on the same cycle as a full-FIFO push -> no overrun, FIFO count stays 4.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling with a fixed
// clock divider, a small byte FIFO popped by a read strobe, and sticky
// framing/overrun error flags.
module uart_rx #(
    parameter int CLKDIV     = 434,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       re,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW    = $clog2(CLKDIV);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKDIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            busy_q;

    logic            rx_meta_q;
    logic            rxs_q;

    logic [7:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0] wptr_d, rptr_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic            tick;
    logic            stop_tick;
    logic            push_req;
    logic            ferr_set;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    // Two-flop synchronizer; presets to the idle-high line level on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick      = (cnt_q == '0);
    assign stop_tick = (state_q == STOP) && tick;
    assign push_req  = stop_tick && rxs_q;
    assign ferr_set  = stop_tick && !rxs_q;

    // Receive FSM: start-bit qualification at half a bit, then one sample per bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxs_q) begin
                            // Line went back high before mid start bit: a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q    <= FULL_LOAD;
                            bitcnt_q <= '0;
                            state_q  <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a directly following start bit is seen.
                    if (tick) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
    assign pop     = re && !empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Next-state for pointers and sticky flags; a set event beats clr_err.
    always_comb begin
        rptr_d      = pop     ? rptr_q + 1'b1 : rptr_q;
        wptr_d      = push_ok ? wptr_q + 1'b1 : wptr_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (ferr_set) frame_err_d = 1'b1;
        if (drop)     overrun_d   = 1'b1;
    end

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
        end
    end

    // FIFO pointers and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rdata     = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
    assign rx_valid  = !empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLKDIV=16 and a 4-entry FIFO.
module tb_uart_rx;

    localparam int CLKDIV = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       re;
    logic       clr_err;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks;
    int errors;

    uart_rx #(.CLKDIV(CLKDIV), .DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .re        (re),
        .clr_err   (clr_err),
        .rdata     (rdata),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full 8N1 frame (160 cycles). Optional re/clr_err pulse lands
    // on the cycle whose closing edge is the STOP-bit sample.
    task automatic send_byte(input logic [7:0] b, input logic stop_val,
                             input logic pop_at_stop, input logic clr_at_stop);
        for (int cyc = 0; cyc < 10 * CLKDIV; cyc++) begin
            int bi;
            bi = cyc / CLKDIV;
            if (bi == 0)      rx = 1'b0;
            else if (bi <= 8) rx = b[bi-1];
            else              rx = stop_val;
            re      = pop_at_stop && (cyc == 154);
            clr_err = clr_at_stop && (cyc == 154);
            @(posedge clk);
            #1;
        end
        rx      = 1'b1;
        re      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic pop_one();
        re = 1'b1;
        step(1);
        re = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
        checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL basic_rdata: got %h expected 55", rdata); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b expected 0", rx_valid); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL basic_pop_rdata: got %h expected 00", rdata); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL pop_empty_valid: got %b expected 0", rx_valid); end
    endtask

    task automatic test_glitch();
        int waited;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        waited = 0;
        while (busy !== 1'b0 && waited < 12) begin
            step(1);
            waited++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_timeout: got %b expected 0 within 12 cycles", busy); end
        step(20);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_framing();
        send_byte(8'hA3, 1'b0, 1'b0, 1'b0);
        step(20);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b expected 1", frame_err); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clr: got %b expected 0", frame_err); end
        send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL frame_next_rdata: got %h expected 3c", rdata); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_next_err: got %b expected 0", frame_err); end
        pop_one();
        // clr_err coincident with the framing error: the set must win.
        send_byte(8'h11, 1'b0, 1'b0, 1'b1);
        step(20);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b expected 1", frame_err); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL set_beats_clr_after: got %b expected 0", frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        for (int k = 1; k <= 5; k++) begin
            exp_b = 8'(k);
            send_byte(exp_b, 1'b1, 1'b0, 1'b0);
            step(2);
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL overrun_frame_err: got %b expected 0", frame_err); end
        for (int k = 1; k <= 4; k++) begin
            exp_b = 8'(k);
            checks++; if (rdata !== exp_b) begin errors++; $display("FAIL overrun_pop%0d: got %h expected %h", k, rdata, exp_b); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_drained: got %b expected 0", rx_valid); end
        pulse_clr();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b expected 0", overrun); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        step(4);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", rdata); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b expected 1", rx_valid); end
        pop_one();
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", rdata); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        b = 8'h96;
        // Start bit plus bits 0..3, then halfway into bit 4.
        for (int cyc = 0; cyc < 5 * CLKDIV + 8; cyc++) begin
            int bi;
            bi = cyc / CLKDIV;
            rx = (bi == 0) ? 1'b0 : b[bi-1];
            step(1);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rx    = 1'b1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", rx_valid); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midreset_rdata: got %h expected 00", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midreset_frame_err: got %b expected 0", frame_err); end
        step(5);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL after_reset_rdata: got %h expected 5a", rdata); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL after_reset_flags: got %b%b expected 00", frame_err, overrun); end
        pop_one();
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] exp_b;
        for (int k = 1; k <= 4; k++) begin
            exp_b = 8'hA0 + 8'(k);
            send_byte(exp_b, 1'b1, 1'b0, 1'b0);
        end
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        step(2);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
        for (int k = 2; k <= 5; k++) begin
            exp_b = 8'hA0 + 8'(k);
            checks++; if (rdata !== exp_b) begin errors++; $display("FAIL simul_pop%0d: got %h expected %h", k, rdata, exp_b); end
            pop_one();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got %b expected 0", rx_valid); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        rx      = 1'b1;
        re      = 1'b0;
        clr_err = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_full_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
